// File: rtl/rv32im_bus_pkg.sv
// rtl/rv32im_bus_pkg.sv - shared state encoding and master indices for the rv32im bus arbiter
package rv32im_bus_pkg;

  // State codes double as the one-hot owner vector driven on gnt_o.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

  localparam int unsigned M_FETCH         = 0;
  localparam int unsigned M_LSU           = 1;
  localparam int unsigned DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/rv32im_rr_arbiter.sv
// rtl/rv32im_rr_arbiter.sv - two-requester round-robin grant, purely combinational
module rv32im_rr_arbiter
  import rv32im_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt[M_FETCH] = 1'b1;
        2'b10:   gnt[M_LSU]   = 1'b1;
        // On contention the master that did not own the bus last time wins.
        2'b11: begin
          if (last_owner == 1'(M_LSU)) gnt[M_FETCH] = 1'b1;
          else                         gnt[M_LSU]   = 1'b1;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/rv32im_bus_arbiter.sv
// rtl/rv32im_bus_arbiter.sv - two-master Wishbone arbiter, fetch vs load/store
// Optional watchdog enabled by defining RV32IM_ARBITER_TIMEOUT_EN.
module rv32im_bus_arbiter
  import rv32im_bus_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk_i,
  input  logic            clear_i,

  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [XLEN-3:0] m0_adr_i,
  input  logic [3:0]      m0_sel_i,
  input  logic [XLEN-1:0] m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [XLEN-3:0] m1_adr_i,
  input  logic [3:0]      m1_sel_i,
  input  logic [XLEN-1:0] m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  output logic [XLEN-1:0] m_dat_o,

  output logic            bus_cyc_o,
  output logic            bus_stb_o,
  output logic            bus_we_o,
  output logic [XLEN-3:0] bus_adr_o,
  output logic [3:0]      bus_sel_o,
  output logic [XLEN-1:0] bus_dat_o,
  input  logic [XLEN-1:0] bus_dat_i,
  input  logic            bus_ack_i,
  input  logic            bus_err_i,

  output logic [1:0]      gnt_o
);

  arb_state_e state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic [1:0] arb_gnt;
  logic       wd_fire;
  logic       wd_kill;

  rv32im_rr_arbiter u_rr (
    .req        ({m1_cyc_i, m0_cyc_i}),
    .last_owner (last_owner),
    .en         (state == ST_IDLE),
    .gnt        (arb_gnt)
  );

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      state      <= ST_IDLE;
      last_owner <= 1'(M_LSU);
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  // Every ownership period ends in IDLE so the waiting master gets a turn.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      ST_IDLE: begin
        if (arb_gnt[M_FETCH]) begin
          state_nxt      = ST_OWN0;
          last_owner_nxt = 1'(M_FETCH);
        end else if (arb_gnt[M_LSU]) begin
          state_nxt      = ST_OWN1;
          last_owner_nxt = 1'(M_LSU);
        end
      end
      ST_OWN0: if (!m0_cyc_i) state_nxt = ST_IDLE;
      ST_OWN1: if (!m1_cyc_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_cyc_o = 1'b0;
    bus_stb_o = 1'b0;
    bus_we_o  = 1'b0;
    bus_adr_o = '0;
    bus_sel_o = '0;
    bus_dat_o = '0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    case (state)
      ST_OWN0: begin
        bus_cyc_o = m0_cyc_i & ~wd_kill;
        bus_stb_o = m0_stb_i & ~wd_kill;
        bus_we_o  = m0_we_i;
        bus_adr_o = m0_adr_i;
        bus_sel_o = m0_sel_i;
        bus_dat_o = m0_dat_i;
        m0_ack_o  = bus_ack_i;
        m0_err_o  = bus_err_i | wd_fire;
      end
      ST_OWN1: begin
        bus_cyc_o = m1_cyc_i & ~wd_kill;
        bus_stb_o = m1_stb_i & ~wd_kill;
        bus_we_o  = m1_we_i;
        bus_adr_o = m1_adr_i;
        bus_sel_o = m1_sel_i;
        bus_dat_o = m1_dat_i;
        m1_ack_o  = bus_ack_i;
        m1_err_o  = bus_err_i | wd_fire;
      end
      default: ;
    endcase
  end

  assign m_dat_o = bus_dat_i;
  assign gnt_o   = state;

`ifdef RV32IM_ARBITER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_dead;
  logic            wd_hit;

  // wd_dead keeps the owner cut off the bus after the single error pulse.
  assign wd_hit  = (wd_cnt == WD_W'(TIMEOUT));
  assign wd_fire = wd_hit & ~wd_dead;
  assign wd_kill = wd_hit | wd_dead;

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      wd_cnt  <= '0;
      wd_dead <= 1'b0;
    end else if (state == ST_IDLE) begin
      wd_cnt  <= '0;
      wd_dead <= 1'b0;
    end else if (bus_ack_i || bus_err_i) begin
      wd_cnt  <= '0;
    end else if (wd_hit) begin
      wd_dead <= 1'b1;
    end else if (bus_stb_o) begin
      wd_cnt  <= wd_cnt + WD_W'(1);
    end
  end
`else
  assign wd_fire = 1'b0;
  assign wd_kill = 1'b0;
`endif

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// tb/tb_rv32im_bus_arbiter.sv - scoreboard bench for rv32im_bus_arbiter
module tb_rv32im_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        clear_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [29:0] m0_adr_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_dat_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [29:0] m1_adr_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_dat_i;
  logic        m1_ack_o, m1_err_o;
  logic [31:0] m_dat_o;
  logic        bus_cyc_o, bus_stb_o, bus_we_o;
  logic [29:0] bus_adr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_dat_o;
  logic [31:0] bus_dat_i;
  logic        bus_ack_i, bus_err_i;
  logic [1:0]  gnt_o;

  rv32im_bus_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
    .clk_i(clk_i), .clear_i(clear_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
    .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
    .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .m_dat_o(m_dat_o),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o), .bus_adr_o(bus_adr_o),
    .bus_sel_o(bus_sel_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
    .bus_ack_i(bus_ack_i), .bus_err_i(bus_err_i), .gnt_o(gnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int           cyc;
    logic [106:0] v;
  } ev_t;

  ev_t sb_q[$];
  int  cyc_n    = 0;
  int  vec_cnt  = 0;
  int  miss_cnt = 0;

  always @(posedge clk_i) cyc_n <= cyc_n + 1;

  // Any cycle with an owner or a response is an event and must match the next expectation.
  always @(negedge clk_i) begin
    logic [106:0] act;
    ev_t          e;
    act = {gnt_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_adr_o, bus_sel_o, bus_dat_o,
           m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m_dat_o};
    if (gnt_o != 2'b00 || bus_cyc_o || m0_ack_o || m0_err_o || m1_ack_o || m1_err_o) begin
      vec_cnt++;
      if (sb_q.size() == 0) begin
        miss_cnt++;
        $display("FAIL unexpected_event cyc=%0d actual=%h required=none", cyc_n, act);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc_n || e.v !== act) begin
          miss_cnt++;
          $display("FAIL event cyc=%0d actual=%h required(cyc %0d)=%h", cyc_n, act, e.cyc, e.v);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic m0_set(input logic c, input logic w, input logic [29:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    m0_cyc_i = c; m0_stb_i = c; m0_we_i = w; m0_adr_i = a; m0_sel_i = s; m0_dat_i = d;
  endtask

  task automatic m1_set(input logic c, input logic w, input logic [29:0] a,
                        input logic [3:0] s, input logic [31:0] d);
    m1_cyc_i = c; m1_stb_i = c; m1_we_i = w; m1_adr_i = a; m1_sel_i = s; m1_dat_i = d;
  endtask

  task automatic slv(input logic ack, input logic err, input logic [31:0] d);
    bus_ack_i = ack; bus_err_i = err; bus_dat_i = d;
  endtask

  task automatic expect_ev(input logic [1:0] g, input logic c, input logic s, input logic w,
                           input logic [29:0] a, input logic [3:0] sl, input logic [31:0] d,
                           input logic a0, input logic e0, input logic a1, input logic e1);
    ev_t e;
    e.cyc = cyc_n;
    e.v   = {g, c, s, w, a, sl, d, a0, e0, a1, e1, bus_dat_i};
    sb_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vec_cnt++;
    if (act !== want) begin
      miss_cnt++;
      $display("FAIL %s actual=%h required=%h", nm, act, want);
    end
  endtask

  initial begin
    clear_i = 1'b1;
    m0_set(1'b1, 1'b1, 30'h3FF, 4'hF, 32'h5555AAAA);
    m1_set(1'b1, 1'b0, 30'h123, 4'h3, 32'h0);
    slv(1'b1, 1'b1, 32'h0);
    repeat (2) tick();
    chk("reset_gnt",     32'(gnt_o), 32'h0);
    chk("reset_bus_cyc", 32'(bus_cyc_o), 32'h0);
    chk("reset_bus_stb", 32'(bus_stb_o), 32'h0);
    chk("reset_bus_adr", 32'(bus_adr_o), 32'h0);
    chk("reset_bus_dat", bus_dat_o, 32'h0);
    chk("reset_acks",    32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'h0);
    m0_set(0, 0, 0, 0, 0); m1_set(0, 0, 0, 0, 0); slv(0, 0, 0);
    tick();
    clear_i = 1'b0;
    tick();

    // contention right after reset: m0 first, then m1, then m0 again
    m0_set(1, 0, 30'h10, 4'hF, 32'h0);
    m1_set(1, 1, 30'h20, 4'hF, 32'h11111111);
    tick(); expect_ev(2'b01, 1, 1, 0, 30'h10, 4'hF, 32'h0, 0, 0, 0, 0);
    tick(); slv(1, 0, 32'hCAFEF00D); m0_set(0, 0, 0, 0, 0);
    expect_ev(2'b01, 0, 0, 0, 30'h0, 4'h0, 32'h0, 1, 0, 0, 0);
    tick(); slv(0, 0, 0);
    tick(); expect_ev(2'b10, 1, 1, 1, 30'h20, 4'hF, 32'h11111111, 0, 0, 0, 0);
    tick(); slv(1, 0, 32'h12345678); m1_set(0, 0, 0, 0, 0);
    expect_ev(2'b10, 0, 0, 0, 30'h0, 4'h0, 32'h0, 0, 0, 1, 0);
    tick(); slv(0, 0, 0);
    m0_set(1, 0, 30'h30, 4'h1, 32'h0);
    m1_set(1, 1, 30'h40, 4'h2, 32'h22222222);
    tick(); expect_ev(2'b01, 1, 1, 0, 30'h30, 4'h1, 32'h0, 0, 0, 0, 0);
    tick(); slv(1, 0, 32'h0); m0_set(0, 0, 0, 0, 0);
    expect_ev(2'b01, 0, 0, 0, 30'h0, 4'h0, 32'h0, 1, 0, 0, 0);
    tick(); slv(0, 0, 0);
    tick(); expect_ev(2'b10, 1, 1, 1, 30'h40, 4'h2, 32'h22222222, 0, 0, 0, 0);
    tick(); slv(1, 0, 32'h0); m1_set(0, 0, 0, 0, 0);
    expect_ev(2'b10, 0, 0, 0, 30'h0, 4'h0, 32'h0, 0, 0, 1, 0);
    tick(); slv(0, 0, 0);
    tick();

    // m1 waits behind m0 while the slave stalls five cycles
    m0_set(1, 0, 30'h0AA, 4'hF, 32'h0);
    tick(); m1_set(1, 0, 30'h0BB, 4'hF, 32'h0);
    expect_ev(2'b01, 1, 1, 0, 30'h0AA, 4'hF, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); expect_ev(2'b01, 1, 1, 0, 30'h0AA, 4'hF, 32'h0, 0, 0, 0, 0);
    end
    tick(); slv(1, 0, 32'h0BADF00D); m0_set(0, 0, 0, 0, 0);
    expect_ev(2'b01, 0, 0, 0, 30'h0, 4'h0, 32'h0, 1, 0, 0, 0);
    tick(); slv(0, 0, 0);
    tick(); expect_ev(2'b10, 1, 1, 0, 30'h0BB, 4'hF, 32'h0, 0, 0, 0, 0);
    tick(); slv(1, 0, 32'h0); m1_set(0, 0, 0, 0, 0);
    expect_ev(2'b10, 0, 0, 0, 30'h0, 4'h0, 32'h0, 0, 0, 1, 0);
    tick(); slv(0, 0, 0);
    tick();

    // bus error on an m0 read
    m0_set(1, 0, 30'h55, 4'hF, 32'h0);
    tick(); expect_ev(2'b01, 1, 1, 0, 30'h55, 4'hF, 32'h0, 0, 0, 0, 0);
    tick(); slv(0, 1, 32'h0);
    expect_ev(2'b01, 1, 1, 0, 30'h55, 4'hF, 32'h0, 0, 1, 0, 0);
    tick(); slv(0, 0, 0); m0_set(0, 0, 0, 0, 0);
    expect_ev(2'b01, 0, 0, 0, 30'h0, 4'h0, 32'h0, 0, 0, 0, 0);
    tick();
    tick();

    // solo m1 store
    m1_set(1, 1, 30'h100, 4'b0011, 32'hDEADBEEF);
    tick(); expect_ev(2'b10, 1, 1, 1, 30'h100, 4'b0011, 32'hDEADBEEF, 0, 0, 0, 0);
    tick(); slv(1, 0, 32'h0);
    expect_ev(2'b10, 1, 1, 1, 30'h100, 4'b0011, 32'hDEADBEEF, 0, 0, 1, 0);
    tick(); slv(0, 0, 0); m1_set(0, 0, 0, 0, 0);
    expect_ev(2'b10, 0, 0, 0, 30'h0, 4'h0, 32'h0, 0, 0, 0, 0);
    tick();
    tick();

    // clear pulsed mid-transfer while the slave acks
    m0_set(1, 1, 30'h77, 4'hF, 32'hA5A5A5A5);
    tick(); expect_ev(2'b01, 1, 1, 1, 30'h77, 4'hF, 32'hA5A5A5A5, 0, 0, 0, 0);
    tick(); slv(1, 0, 32'h0); clear_i = 1'b1;
    #1;
    chk("clear_bus_cyc", 32'(bus_cyc_o), 32'h0);
    chk("clear_bus_stb", 32'(bus_stb_o), 32'h0);
    chk("clear_gnt",     32'(gnt_o), 32'h0);
    chk("clear_acks",    32'({m0_ack_o, m1_ack_o}), 32'h0);
    tick(); m0_set(0, 0, 0, 0, 0); slv(0, 0, 0); clear_i = 1'b0;
    tick();

`ifdef RV32IM_ARBITER_TIMEOUT_EN
    // slave never answers: error pulse four cycles after the grant
    m0_set(1, 0, 30'h99, 4'hF, 32'h0);
    tick(); expect_ev(2'b01, 1, 1, 0, 30'h99, 4'hF, 32'h0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_ev(2'b01, 1, 1, 0, 30'h99, 4'hF, 32'h0, 0, 0, 0, 0);
    end
    tick(); expect_ev(2'b01, 0, 0, 0, 30'h99, 4'hF, 32'h0, 0, 1, 0, 0);
    tick(); m0_set(0, 0, 0, 0, 0);
    expect_ev(2'b01, 0, 0, 0, 30'h0, 4'h0, 32'h0, 0, 0, 0, 0);
    tick();
    tick();
`endif

    repeat (3) tick();
    while (sb_q.size() != 0) begin
      ev_t e;
      e = sb_q.pop_front();
      vec_cnt++;
      miss_cnt++;
      $display("FAIL missing_event actual=none required(cyc %0d)=%h", e.cyc, e.v);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
